// File: rtl/mux_pkg.sv
// Shared constants for the 4:1 select mux: select-index encodings and default width.
package mux_pkg;

  localparam int unsigned DEFAULT_WIDTH = 1;
  localparam int unsigned SEL_W         = 2;

  localparam logic [SEL_W-1:0] SEL_I0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_I1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_I2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_I3 = 2'b11;

  // Select index is {s0,s1}: s0 is the MSB, s1 the LSB.
  function automatic logic [SEL_W-1:0] sel_index(input logic s0, input logic s1);
    return {s0, s1};
  endfunction

endpackage

// File: rtl/mux_2x1.sv
// Bitwise 2:1 mux; an unknown select yields an unknown result.
module mux_2x1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = 'x;
    case (sel)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux_4x1.sv
// 4:1 mux built from three 2:1 muxes, with an enabled output register and a
// registered select-change flag.
module mux_4x1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned OUT_REG = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s1,
  input  logic             s0,
  input  logic             en,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_q,
  output logic             sel_chg
);

  logic [WIDTH-1:0] lo_sel;
  logic [WIDTH-1:0] hi_sel;
  logic [WIDTH-1:0] sel_data;
  logic [SEL_W-1:0] sel_cur;

  // First level picks within each pair by s1; second level picks the pair by s0.
  mux_2x1 #(.WIDTH(WIDTH)) u_mux_lo (.a(i0),     .b(i1),     .sel(s1), .y(lo_sel));
  mux_2x1 #(.WIDTH(WIDTH)) u_mux_hi (.a(i2),     .b(i3),     .sel(s1), .y(hi_sel));
  mux_2x1 #(.WIDTH(WIDTH)) u_mux_top(.a(lo_sel), .b(hi_sel), .sel(s0), .y(sel_data));

  assign sel_cur = sel_index(s0, s1);

  logic [WIDTH-1:0] data_d,     data_q;
  logic [SEL_W-1:0] sel_prev_d, sel_prev_q;
  logic             sel_chg_d,  sel_chg_q;

  always_comb begin
    data_d     = data_q;
    sel_prev_d = sel_cur;
    sel_chg_d  = (sel_cur != sel_prev_q);
    if (en) begin
      data_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      sel_prev_q <= SEL_I0;
      sel_chg_q  <= 1'b0;
    end else begin
      data_q     <= data_d;
      sel_prev_q <= sel_prev_d;
      sel_chg_q  <= sel_chg_d;
    end
  end

  assign d_q     = data_q;
  assign sel_chg = sel_chg_q;

  // Output source is fixed at elaboration.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      assign d = data_q;
    end else begin : g_out_comb
      assign d = sel_data;
    end
  endgenerate

endmodule

// File: tb/tb_mux_4x1.sv
// Directed self-checking bench: one combinational-output and one registered-output instance.
module tb_mux_4x1;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] i0, i1, i2, i3;
  logic         s0, s1, en;
  logic [W-1:0] d_c, dq_c, d_r, dq_r;
  logic         chg_c, chg_r;

  int vectors;
  int miscompares;

  mux_4x1 #(.WIDTH(W), .OUT_REG(0)) dut_c (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s1(s1), .s0(s0), .en(en), .d(d_c), .d_q(dq_c), .sel_chg(chg_c)
  );

  mux_4x1 #(.WIDTH(W), .OUT_REG(1)) dut_r (
    .clk(clk), .rst(rst), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .s1(s1), .s0(s0), .en(en), .d(d_r), .d_q(dq_r), .sel_chg(chg_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] e,
                        input logic hs0, input logic hs1);
    i0 = a; i1 = b; i2 = c; i3 = e; s0 = hs0; s1 = hs1;
  endtask

  initial begin
    logic [W-1:0] exp;
    logic [1:0]   idx;
    vectors     = 0;
    miscompares = 0;

    // Reset with all inputs low.
    rst = 1'b1; en = 1'b0;
    set_in(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    edge_step();
    check("rst_dq_c",  dq_c,  4'h0);
    check("rst_dq_r",  dq_r,  4'h0);
    check("rst_chg_c", {3'b000, chg_c}, 4'h0);
    check("rst_d_r",   d_r,   4'h0);
    // Combinational path live while reset is held.
    i0 = 4'h5; #1;
    check("rst_comb_track", d_c, 4'h5);
    @(negedge clk);
    rst = 1'b0;

    // Directed single-hot cases.
    set_in(4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b1); #1; check("case_i3", d_c, 4'h1);
    set_in(4'h1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0); #1; check("case_i0", d_c, 4'h1);
    set_in(4'h0, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1); #1; check("case_i1", d_c, 4'h1);
    set_in(4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0); #1; check("case_i2", d_c, 4'h1);

    // Walking one across inputs and all select values.
    for (int hot = 0; hot < 4; hot++) begin
      for (int s = 0; s < 4; s++) begin
        idx = 2'(s);
        set_in((hot == 0) ? 4'h1 : 4'h0, (hot == 1) ? 4'h1 : 4'h0,
               (hot == 2) ? 4'h1 : 4'h0, (hot == 3) ? 4'h1 : 4'h0, idx[1], idx[0]);
        #1;
        exp = (s == hot) ? 4'h1 : 4'h0;
        check($sformatf("walk_h%0d_s%0d", hot, s), d_c, exp);
      end
    end

    // Multi-bit patterns, then data change with stable select.
    set_in(4'hA, 4'h5, 4'hC, 4'h3, 1'b0, 1'b0); #1; check("wide_i0", d_c, 4'hA);
    s1 = 1'b1; #1;                                  check("wide_i1", d_c, 4'h5);
    s0 = 1'b1; s1 = 1'b0; #1;                       check("wide_i2", d_c, 4'hC);
    s1 = 1'b1; #1;                                  check("wide_i3", d_c, 4'h3);
    i3 = 4'h9; #1;                                  check("data_follow", d_c, 4'h9);
    // en has been low since reset, so the register still holds zero.
    check("hold_since_rst", dq_c, 4'h0);

    // Registered output: load on enabled edge, hold when disabled.
    @(negedge clk);
    set_in(4'h0, 4'h0, 4'h1, 4'h0, 1'b1, 1'b0);
    en = 1'b1; #1;
    check("oreg_before", d_r, 4'h0);
    edge_step();
    check("oreg_after",  d_r,  4'h1);
    check("oreg_dq",     dq_r, 4'h1);
    @(negedge clk);
    en = 1'b0; i2 = 4'h0;
    edge_step();
    check("oreg_hold",   d_r,  4'h1);
    check("comb_i2_low", d_c,  4'h0);

    // Select change detector: 10 -> 00 settles, then 00 -> 11.
    @(negedge clk);
    s0 = 1'b0; s1 = 1'b0;
    edge_step();
    edge_step();
    check("chg_idle00", {3'b000, chg_c}, 4'h0);
    @(negedge clk);
    s0 = 1'b1; s1 = 1'b1;
    edge_step();
    check("chg_pulse",  {3'b000, chg_c}, 4'h1);
    check("chg_pulse_r", {3'b000, chg_r}, 4'h1);
    edge_step();
    check("chg_drop",   {3'b000, chg_c}, 4'h0);

    // Reset mid-run: beats en and a select change; comb path unaffected.
    @(negedge clk);
    rst = 1'b1; en = 1'b1;
    set_in(4'h7, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    edge_step();
    check("mrst_dq",   dq_r, 4'h0);
    check("mrst_dr",   d_r,  4'h0);
    check("mrst_chg",  {3'b000, chg_r}, 4'h0);
    check("mrst_comb", d_c,  4'h7);

    // First edge after reset compares against 00.
    @(negedge clk);
    rst = 1'b0; en = 1'b0;
    edge_step();
    check("post_rst_00", {3'b000, chg_c}, 4'h0);
    @(negedge clk);
    s1 = 1'b1;
    edge_step();
    check("post_rst_01", {3'b000, chg_c}, 4'h1);
    check("post_rst_hold", dq_c, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_4x1.md
MUX_4X1 -- requirements
Module: mux_4x1

Interface
REQ-001 Parameter WIDTH, default 1, data width of each input and output.
REQ-002 Parameter OUT_REG, default 0: 0 = output d is combinational; 1 = output d is taken from the registered stage.
REQ-003 Port clk  input  1  single clock; all registers update on the rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port d  output  WIDTH  selected data, combinational or registered per OUT_REG.
REQ-006 Ports i0, i1, i2, i3  input  WIDTH  each a data candidate.
REQ-007 Port s1  input  1  select bit, LSB of the select index.
REQ-008 Port s0  input  1  select bit, MSB of the select index.
REQ-009 Port en  input  1  load enable for the registered stage.
REQ-010 Port d_q  output  WIDTH  registered copy of the selected data, independent of OUT_REG.
REQ-011 Port sel_chg  output  1  registered flag: the select index changed since the previous cycle.

Function
REQ-012 Select index SHALL be {s0,s1}: 00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3.
REQ-013 Combinational selection SHALL have zero latency, with no clock involvement.
REQ-014 With OUT_REG=0, d SHALL equal the combinational selection at all times, including during reset.
REQ-015 With OUT_REG=1, d SHALL equal d_q.
REQ-016 d_q SHALL load the combinational selection on each rising edge with en=1, and SHALL hold its value when en=0.
REQ-017 sel_chg SHALL be 1 for exactly one cycle after any edge where the sampled {s0,s1} differs from the value sampled on the previous edge; otherwise 0.
REQ-018 sel_chg sampling SHALL ignore en.
REQ-019 Selection SHALL apply bitwise across all WIDTH bits with the same index.
REQ-020 No width extension or truncation SHALL occur anywhere.
REQ-021 If a select bit is X or Z, the combinational result SHALL be X.
REQ-022 Data inputs changing while the select is stable SHALL propagate to d immediately when OUT_REG=0.

Reset
REQ-023 On a rising edge with rst=1, d_q SHALL clear to 0, sel_chg SHALL clear to 0, and the stored previous select SHALL clear to 00.
REQ-024 rst SHALL take priority over en.
REQ-025 The first edge after reset SHALL compare the select against 00.
REQ-026 Reset asserted mid-operation SHALL clear the registers at the next edge without affecting the combinational path.

Structure
REQ-027 Shared package mux_pkg SHALL hold the select-index encoding constants SEL_I0..SEL_I3 (2-bit) and the default WIDTH.
REQ-028 One sub-module, mux_2x1 (parameterised WIDTH), SHALL be instantiated three times: two first-level muxes select by s1, and the second level selects by s0.
REQ-029 The registered stage and change detector SHALL reside in mux_4x1 itself.

Verification
REQ-030 Case: i0=0, i1=0, i2=0, i3=1, s0=1, s1=1 -> d=1.
REQ-031 Case: i0=1, others 0, s0=0, s1=0 -> d=1; case: i1=1, others 0, s0=0, s1=1 -> d=1; case: i2=1, others 0, s0=1, s1=0 -> d=1.
REQ-032 Exhaustive walking-one over all 4 inputs x 4 select values -> d is 1 only when the index matches the hot input.
REQ-033 OUT_REG=1, en=1, select=10, i2=1 -> d=0 before the edge, d=1 after one rising edge; then en=0 with i2=0 -> d stays 1.
REQ-034 Select changes 00 -> 11 at one edge -> sel_chg=1 for one cycle, then 0 while the select holds.
REQ-035 rst=1 for one edge with d_q=1 -> d_q=0 and sel_chg=0 at that edge, while the combinational d (OUT_REG=0) still tracks its inputs.
